// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Constants shared by the datapath selection blocks.
//   MODE_DIRECT   : the mode value for selecting the channel named by op.
//   MODE_RR       : the mode value for selecting through the fair arbiter.
//   DEFAULT_WIDTH : the default channel and output data width.
// -----------------------------------------------------------------------------
package datapath_pkg;

    localparam logic MODE_DIRECT   = 1'b0;
    localparam logic MODE_RR       = 1'b1;
    localparam int   DEFAULT_WIDTH = 16;

endpackage : datapath_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// A purely combinational round-robin arbiter. The scan starts at
// last_grant+1 modulo NUM_IN and returns the first requesting channel.
// The pointer register belongs to the parent.
//   req         in   NUM_IN  request vector
//   last_grant  in   SEL_W   index granted on the most recent transfer
//   grant_valid out  1       at least one request is set
//   grant_idx   out  SEL_W   chosen channel (0 when grant_valid is low)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  last_grant,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, so no path leaves it unassigned and no
        // latch is inferred.
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        // The walk runs from the farthest offset down to the nearest one.
        // The last hit to be written is then the closest channel after
        // last_grant, which is the one that has priority.
        for (int off = NUM_IN; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_IN;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/param_mux_pipe.sv
// -----------------------------------------------------------------------------
// param_mux_pipe
// Selects one of NUM_IN request channels, either directly by op or through a
// round-robin arbiter. The chosen word is registered into a one-deep output
// stage that uses valid/ready flow control.
//   clock      in   1             rising-edge clock
//   reset      in   1             asynchronous active-low reset
//   in_data    in   NUM_IN*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NUM_IN        per-channel request
//   in_ready   out  NUM_IN        per-channel accept (one-hot or zero)
//   mode       in   1             MODE_DIRECT / MODE_RR
//   op         in   SEL_W         channel index used in direct mode
//   out_data   out  WIDTH         registered selected word
//   out_src    out  SEL_W         channel that produced out_data
//   out_valid  out  1             the stage holds an unconsumed word
//   out_ready  in   1             downstream takes the word this cycle
// -----------------------------------------------------------------------------
module param_mux_pipe
    import datapath_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        op,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // op can address every slot that SEL_W bits can name. Any slot at or
    // above NUM_IN reads as "not valid", so an out-of-range op gives no grant.
    localparam int NUM_SLOTS = 2 ** SEL_W;

    logic                 load;
    logic [NUM_SLOTS-1:0] valid_ext;
    logic                 direct_grant;
    logic                 rr_grant_valid;
    logic [SEL_W-1:0]     rr_grant_idx;
    logic                 grant;
    logic [SEL_W-1:0]     grant_idx;
    logic [WIDTH-1:0]     grant_data;

    logic [WIDTH-1:0]     out_data_q,   out_data_d;
    logic [SEL_W-1:0]     out_src_q,    out_src_d;
    logic                 out_valid_q,  out_valid_d;
    logic [SEL_W-1:0]     last_grant_q, last_grant_d;

    // The stage can take a word if it is empty or if its word leaves this cycle.
    assign load         = !out_valid_q || out_ready;
    assign valid_ext    = NUM_SLOTS'(in_valid);
    assign direct_grant = valid_ext[op];

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_rr_arbiter (
        .req         (in_valid),
        .last_grant  (last_grant_q),
        .grant_valid (rr_grant_valid),
        .grant_idx   (rr_grant_idx)
    );

    always_comb begin
        grant     = (mode == MODE_RR) ? rr_grant_valid : direct_grant;
        grant_idx = (mode == MODE_RR) ? rr_grant_idx   : op;
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load && grant;
            end
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (grant) begin
                out_data_d   = grant_data;
                out_src_d    = grant_idx;
                out_valid_d  = 1'b1;
                // Both modes move the pointer, so a later switch to
                // round-robin continues fairly from the last source.
                last_grant_d = grant_idx;
            end else begin
                // When nothing is granted, only the valid flag drops. The
                // data and source stay visible for debugging.
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data_q   <= '0;
            out_src_q    <= '0;
            out_valid_q  <= 1'b0;
            // The pointer starts at the top channel, so channel 0 has first
            // priority after reset.
            last_grant_q <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule : param_mux_pipe

// File: tb/tb_param_mux_pipe.sv
module tb_param_mux_pipe;

    logic clk;
    logic rst_n;

    // Four-channel instance
    logic [63:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic        mode4;
    logic [1:0]  op4;
    logic [15:0] out_data4;
    logic [1:0]  out_src4;
    logic        out_valid4;
    logic        out_ready4;

    // Three-channel instance
    logic [47:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  op3;
    logic [15:0] out_data3;
    logic [1:0]  out_src3;
    logic        out_valid3;
    logic        out_ready3;

    int checks = 0;
    int fails  = 0;

    param_mux_pipe #(.WIDTH(16), .NUM_IN(4)) u_dut4 (
        .clock     (clk),
        .reset     (rst_n),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .mode      (mode4),
        .op        (op4),
        .out_data  (out_data4),
        .out_src   (out_src4),
        .out_valid (out_valid4),
        .out_ready (out_ready4)
    );

    param_mux_pipe #(.WIDTH(16), .NUM_IN(3)) u_dut3 (
        .clock     (clk),
        .reset     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .op        (op3),
        .out_data  (out_data3),
        .out_src   (out_src3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        mode;
        logic [1:0]  op;
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t tbl[17];

    // Reference model state for the four-channel instance
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_src;
    int          m_last;

    initial begin
        // Table data: ch3=4444 ch2=BEEF ch1=2222 ch0=1111.
        tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0};
        tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0};
        tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0};
        tbl[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1};
        tbl[11] = '{1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 16'h2222, 2'd1};
        tbl[12] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 16'h4444, 2'd3};
        tbl[13] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1};
        tbl[14] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0};
        tbl[15] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0};
        tbl[16] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1111, 2'd0};

        rst_n      = 1'b0;
        in_data4   = '0;
        in_valid4  = '0;
        mode4      = 1'b0;
        op4        = '0;
        out_ready4 = 1'b0;
        in_data3   = '0;
        in_valid3  = '0;
        mode3      = 1'b0;
        op3        = '0;
        out_ready3 = 1'b0;

        // ---------------- reset state ----------------
        #1;
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_out_data",  32'(out_data4),  32'd0);
        check("rst_out_src",   32'(out_src4),   32'd0);
        check("rst_out_valid3", 32'(out_valid3), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_out_valid", 32'(out_valid4), 32'd0);
            check("idle_out_data",  32'(out_data4),  32'd0);
            check("idle_in_ready",  32'(in_ready4),  32'd0);
        end

        // ---------------- table-driven vectors ----------------
        in_data4 = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
        for (int v = 0; v < 17; v++) begin
            mode4      = tbl[v].mode;
            op4        = tbl[v].op;
            in_valid4  = tbl[v].valid;
            out_ready4 = tbl[v].rdy;
            #1;
            check($sformatf("vec%0d_in_ready", v), 32'(in_ready4), 32'(tbl[v].exp_ready));
            tick();
            check($sformatf("vec%0d_out_valid", v), 32'(out_valid4), 32'(tbl[v].exp_valid));
            check($sformatf("vec%0d_out_data", v),  32'(out_data4),  32'(tbl[v].exp_data));
            check($sformatf("vec%0d_out_src", v),   32'(out_src4),   32'(tbl[v].exp_src));
        end

        // ---------------- NUM_IN = 3, out-of-range op ----------------
        in_data3   = {16'h3333, 16'h2222, 16'h1111};
        mode3      = 1'b0;
        op3        = 2'd0;
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        #1;
        check("n3_load_in_ready", 32'(in_ready3), 32'b001);
        tick();
        check("n3_load_valid", 32'(out_valid3), 32'd1);
        check("n3_load_data",  32'(out_data3),  32'h1111);
        op3        = 2'd3;
        out_ready3 = 1'b0;
        #1;
        check("n3_op3_hold_in_ready", 32'(in_ready3), 32'd0);
        tick();
        check("n3_op3_hold_valid", 32'(out_valid3), 32'd1);
        out_ready3 = 1'b1;
        #1;
        check("n3_op3_in_ready", 32'(in_ready3), 32'd0);
        tick();
        check("n3_op3_valid_drop", 32'(out_valid3), 32'd0);
        check("n3_op3_data_hold",  32'(out_data3),  32'h1111);
        check("n3_op3_src_hold",   32'(out_src3),   32'd0);
        in_valid3 = '0;

        // ---------------- asynchronous reset mid-stream ----------------
        mode4      = 1'b1;
        in_valid4  = 4'b1111;
        out_ready4 = 1'b1;
        tick();
        check("mid_pre_valid", 32'(out_valid4), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(out_valid4), 32'd0);
        check("mid_async_data",  32'(out_data4),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_first_in_ready", 32'(in_ready4), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr_seq%0d_src", k), 32'(out_src4), 32'(k % 4));
            check($sformatf("rr_seq%0d_valid", k), 32'(out_valid4), 32'd1);
        end

        // ---------------- randomized run against the reference model ----------------
        in_valid4 = '0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
        m_valid   = 1'b0;
        m_data    = '0;
        m_src     = '0;
        m_last    = 3;
        for (int n = 0; n < 400; n++) begin
            logic       ld;
            logic       gnt;
            int         g;
            logic [3:0] exp_rdy;
            mode4      = 1'($urandom_range(0, 1));
            op4        = 2'($urandom_range(0, 3));
            in_valid4  = 4'($urandom);
            out_ready4 = ($urandom_range(0, 3) != 0);
            in_data4   = {$urandom, $urandom};

            ld  = !m_valid || out_ready4;
            gnt = 1'b0;
            g   = 0;
            if (mode4 == 1'b0) begin
                gnt = in_valid4[op4];
                g   = int'(op4);
            end else begin
                for (int s = 1; s <= 4; s++) begin
                    int ch;
                    ch = (m_last + s) % 4;
                    if (!gnt && in_valid4[ch]) begin
                        gnt = 1'b1;
                        g   = ch;
                    end
                end
            end
            exp_rdy = (ld && gnt) ? 4'(1 << g) : 4'b0000;

            #1;
            check("rand_in_ready", 32'(in_ready4), 32'(exp_rdy));
            tick();
            if (ld && gnt) begin
                m_valid = 1'b1;
                m_data  = in_data4[g*16 +: 16];
                m_src   = 2'(g);
                m_last  = g;
            end else if (ld) begin
                m_valid = 1'b0;
            end
            check("rand_out_valid", 32'(out_valid4), 32'(m_valid));
            check("rand_out_data",  32'(out_data4),  32'(m_data));
            check("rand_out_src",   32'(out_src4),   32'(m_src));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_param_mux_pipe

// File: doc/param_mux_pipe.md
Name: param_mux_pipe

Overview:
- Parametrised successor to the team's registered four-way 16-bit mux.
- Selects one of NUM_IN request channels and registers the chosen word into a one-deep output stage with valid/ready flow control.
- Two modes:
  - Direct: selection by `op`.
  - Round-robin: selection by a fair arbiter.
- Sits between datapath producers (register file ports, ALU result, immediates, memory read) and downstream pipeline consumers that may stall.

Parameters:
- WIDTH, 16: data width of each channel and of out_data.
- NUM_IN, 4: number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN): width of op and out_src; derived, never overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel request.
- in_ready  output  NUM_IN  per-channel accept; combinational, at most one bit high.
- mode  input  1  0 = direct select, 1 = round-robin.
- op  input  SEL_W  channel index used in direct mode.
- out_data  output  WIDTH  registered selected word.
- out_src  output  SEL_W  registered index of the channel that produced out_data.
- out_valid  output  1  out_data/out_src hold an unconsumed word.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (reset low, asynchronous):
  - out_data = 0, out_src = 0, out_valid = 0.
  - Round-robin pointer last_grant = NUM_IN-1, so channel 0 has first priority.
- Load enable: load = !out_valid || out_ready. A full, unaccepted stage holds all outputs stable, and in_ready is all zero.
- Direct mode (mode = 0):
  - Candidate = op.
  - Grant exists iff op < NUM_IN and in_valid[op].
  - An out-of-range op (only possible when NUM_IN is not a power of two) gives no grant and no error.
- Round-robin mode (mode = 1):
  - Candidate = first valid channel scanning upward from last_grant+1 modulo NUM_IN.
  - Grant exists iff any in_valid bit is set.
- in_ready[i] = load && grant && (granted index == i), combinational from the current inputs.
- Transfer on a rising edge when load && grant:
  - out_data ← granted channel data.
  - out_src ← granted index.
  - out_valid ← 1.
- last_grant updates to the granted index on every transfer in either mode, so a switch to round-robin continues fairly from the last source.
- load && !grant: out_valid ← 0; out_data and out_src hold their previous values.
- Latency: one cycle from accepted input to out_valid. Full throughput of one word per cycle when out_ready stays high.
- Simultaneous out_ready and a new grant in the same cycle: the old word is consumed and the new word is loaded on the same edge; there is no bubble.
- Wrap-around: when last_grant = NUM_IN-1 the scan starts at channel 0.
- Mode or op changes take effect combinationally in the same cycle. A word already in the stage is unaffected.
- Reset asserted mid-transfer: the output word is discarded, out_valid drops immediately (asynchronously), and the pointer returns to NUM_IN-1.

Decomposition:
- Shared package datapath_pkg holds:
  - MODE_DIRECT = 1'b0 and MODE_RR = 1'b1.
  - The default WIDTH constant of 16.
- One sub-module, rr_arbiter (parameter NUM_IN):
  - Inputs: request vector, last_grant pointer.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational; the pointer register stays in param_mux_pipe.

Test Plan:
- Reset, then release with all in_valid = 0 → out_valid = 0, out_data = 0, in_ready = 0000 for 5 cycles.
- Direct mode, NUM_IN = 4:
  - Stimulus: op = 2, in_valid = 1111, in_data ch2 = 16'hBEEF, out_ready = 1.
  - Required: in_ready = 0100; next cycle out_data = BEEF, out_src = 2, out_valid = 1.
- Round-robin mode, all four channels valid continuously, out_ready = 1 → out_src sequence is 0,1,2,3,0,1, one word per cycle.
- Backpressure:
  - Stimulus: round-robin with a word loaded, out_ready = 0 for 3 cycles.
  - Required: out_data and out_src stable, in_ready = 0000, last_grant unchanged.
  - Then out_ready = 1 → the next channel loads on the same edge the old word is consumed.
- NUM_IN = 3, direct mode, op = 3 with all channels valid → no grant, in_ready = 000, out_valid falls to 0 after the current word is consumed.
- Reset pulsed low mid-stream with out_valid = 1 → out_valid = 0 immediately, without waiting for a clock edge. After release, the first round-robin grant goes to channel 0.
